// File: rtl/mips_mux_pkg.sv
// Shared defaults and buffer state encoding for the pipelined N-to-1 mux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default WIDTH/NUM_IN and the EMPTY/ONE/TWO occupancy states.
package mips_mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  // Occupancy of the two-entry (head + skid) buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 word selector with out-of-range detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
//
// Ports: in_data (NUM_IN packed words, word k at [k*WIDTH +: WIDTH]),
//        sel (index), out_data (selected word, 0 when out of range),
//        sel_err (high when sel >= NUM_IN).
module mux_nto1
  import mips_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_err
);

  // Start from "no match": an index no input claims yields zero data and
  // the error flag, which covers non-power-of-two NUM_IN.
  always_comb begin
    out_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Pipelined N-to-1 mux: selects a word at acceptance and buffers it in a 2-deep head+skid FIFO.
// Latency: 1 cycle from acceptance to out_valid when the buffer was empty; 1 beat/cycle sustained.
// Backpressure: valid/ready; in_ready is registered from occupancy only (low when both entries full).
//
// Ports: clk, rst_n (sync, active-low), in_data/sel/in_valid/in_ready (upstream),
//        flush (drop buffered beats), out_data/out_valid/out_ready (downstream),
//        sel_err (sticky until reset: an out-of-range sel was accepted).
module mux_nto1_pipe
  import mips_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             sel_err_q, sel_err_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  logic             accept;
  logic             consume;

  // Selection happens on the incoming beat, so the stored word never
  // depends on in_data from a later cycle.
  mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (mux_word),
    .sel_err  (mux_err)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_d    = skid_q;
    // An out-of-range beat still counts as accepted even if flushed.
    sel_err_d = sel_err_q | (accept & mux_err);

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = mux_word;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          head_d = mux_word;
        end else if (accept) begin
          skid_d  = mux_word;
          state_d = ST_TWO;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a consume can move the buffer.
        if (consume) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d = ST_EMPTY;
    end

    // Registered ready: derived from next occupancy, so no path from out_ready.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      sel_err_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      sel_err_q  <= sel_err_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Stale head contents are masked so an empty buffer always shows zero.
  assign out_data = out_valid ? head_q : '0;
  assign in_ready = in_ready_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Testbench for mux_nto1_pipe: directed vector table, NUM_IN=3 error sequence, randomized model check.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux_nto1_pipe;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic           clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_data;
  logic [1:0]     sel = '0;
  logic           in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready = 1'b0, sel_err;

  // NUM_IN=3 instance for out-of-range selects
  logic             rst3_n = 1'b0;
  logic [N3*W3-1:0] in_data3;
  logic [1:0]       sel3 = '0;
  logic             in_valid3 = 1'b0, in_ready3, flush3 = 1'b0;
  logic [W3-1:0]    out_data3;
  logic             out_valid3, out_ready3 = 1'b0, sel_err3;

  mux_nto1_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  mux_nto1_pipe #(.WIDTH(W3), .NUM_IN(N3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One row = inputs driven for one cycle + outputs expected after that edge.
  typedef struct {
    bit         rst_n;
    bit         in_valid;
    bit [1:0]   sel;
    bit         out_ready;
    bit         flush;
    bit         exp_ov;
    bit [31:0]  exp_od;
    bit         exp_ir;
    bit         exp_se;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit iv, bit [1:0] s, bit ordy, bit fl,
                              bit ov, bit [31:0] od, bit ir, bit se);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.sel = s; v.out_ready = ordy; v.flush = fl;
    v.exp_ov = ov; v.exp_od = od; v.exp_ir = ir; v.exp_se = se;
    return v;
  endfunction

  task automatic step3(input bit r, input bit iv, input bit [1:0] s,
                       input bit ordy, input bit fl);
    rst3_n = r; in_valid3 = iv; sel3 = s; out_ready3 = ordy; flush3 = fl;
    @(negedge clk);
  endtask

  // Reference model state: plain FIFO of words plus sticky error bit.
  logic [W-1:0] mq[$];
  bit           m_se;

  initial begin
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'((k + 1) * 32'h11);
    for (int k = 0; k < N3; k++) in_data3[k*W3 +: W3] = W3'((k + 1) * 8'h11);

    // ---------------- directed vector table ----------------
    //            rst iv sel ordy fl | ov  od         ir se
    vecs.push_back(mk(0, 0, 0, 0, 0,   0, 32'h00, 1, 0)); // reset state
    vecs.push_back(mk(1, 1, 2, 1, 0,   1, 32'h33, 1, 0)); // latency 1
    vecs.push_back(mk(1, 1, 0, 1, 0,   1, 32'h11, 1, 0)); // back-to-back
    vecs.push_back(mk(1, 1, 1, 1, 0,   1, 32'h22, 1, 0));
    vecs.push_back(mk(1, 1, 2, 1, 0,   1, 32'h33, 1, 0));
    vecs.push_back(mk(1, 1, 3, 1, 0,   1, 32'h44, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,   0, 32'h00, 1, 0)); // drain
    vecs.push_back(mk(1, 1, 0, 0, 0,   1, 32'h11, 1, 0)); // stall: 1st beat
    vecs.push_back(mk(1, 1, 1, 0, 0,   1, 32'h11, 0, 0)); // 2nd beat, full
    vecs.push_back(mk(1, 1, 2, 0, 0,   1, 32'h11, 0, 0)); // 3rd refused, head stable
    vecs.push_back(mk(1, 1, 2, 1, 0,   1, 32'h22, 1, 0)); // release: 11 out
    vecs.push_back(mk(1, 1, 2, 1, 0,   1, 32'h33, 1, 0)); // 22 out, 3rd accepted
    vecs.push_back(mk(1, 0, 0, 1, 0,   0, 32'h00, 1, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0,   1, 32'h44, 1, 0)); // fill to TWO
    vecs.push_back(mk(1, 1, 0, 0, 0,   1, 32'h44, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1,   0, 32'h00, 1, 0)); // flush wins
    vecs.push_back(mk(1, 0, 0, 1, 0,   0, 32'h00, 1, 0)); // nothing retained
    vecs.push_back(mk(1, 1, 1, 0, 0,   1, 32'h22, 1, 0)); // fill to TWO again
    vecs.push_back(mk(1, 1, 2, 0, 0,   1, 32'h22, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1,   0, 32'h00, 1, 0)); // reset in TWO
    vecs.push_back(mk(1, 0, 0, 1, 0,   0, 32'h00, 1, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; in_valid = vecs[i].in_valid; sel = vecs[i].sel;
      out_ready = vecs[i].out_ready; flush = vecs[i].flush;
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_data", i),  out_data,       vecs[i].exp_od);
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ir));
      check($sformatf("vec%0d sel_err", i),   32'(sel_err),   32'(vecs[i].exp_se));
    end

    // ---------------- NUM_IN=3: out-of-range select ----------------
    step3(0, 0, 0, 0, 0);
    check("n3 reset sel_err", 32'(sel_err3), 0);
    check("n3 reset out_valid", 32'(out_valid3), 0);
    step3(1, 1, 3, 1, 0);
    check("n3 bad sel out_valid", 32'(out_valid3), 1);
    check("n3 bad sel out_data", 32'(out_data3), 0);
    check("n3 bad sel sel_err", 32'(sel_err3), 1);
    step3(1, 0, 0, 1, 1);
    check("n3 flush out_valid", 32'(out_valid3), 0);
    check("n3 sel_err after flush", 32'(sel_err3), 1);
    step3(1, 1, 0, 0, 0);
    check("n3 fill1 out_data", 32'(out_data3), 32'h11);
    step3(1, 1, 3, 0, 0);
    check("n3 fill2 in_ready", 32'(in_ready3), 0);
    check("n3 fill2 head stable", 32'(out_data3), 32'h11);
    step3(0, 1, 1, 1, 0);
    check("n3 rst-in-TWO out_valid", 32'(out_valid3), 0);
    check("n3 rst-in-TWO out_data", 32'(out_data3), 0);
    check("n3 rst-in-TWO sel_err", 32'(sel_err3), 0);
    check("n3 rst-in-TWO in_ready", 32'(in_ready3), 1);

    // ---------------- randomized run against FIFO model ----------------
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    mq.delete(); m_se = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit          r, iv, ordy, fl, acc, cons;
      logic [W-1:0] word;
      // Check current outputs against model
      check("rnd out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("rnd out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
      check("rnd in_ready", 32'(in_ready), 32'(mq.size() < 2));
      check("rnd sel_err", 32'(sel_err), 32'(m_se));
      // New stimulus
      r    = ($urandom_range(63) != 0);
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      fl   = ($urandom_range(11) == 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
      sel = 2'($urandom_range(N - 1));
      rst_n = r; in_valid = iv; out_ready = ordy; flush = fl;
      word = in_data[int'(sel)*W +: W];
      if (!r) begin
        mq.delete(); m_se = 1'b0;
      end else begin
        acc  = iv && (mq.size() < 2);
        cons = ordy && (mq.size() > 0);
        if (fl) begin
          mq.delete();
        end else begin
          if (cons) void'(mq.pop_front());
          if (acc) mq.push_back(word);
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
